clk_div_ctrl: RTL

//  Run-time programmable clock-divider controller. Generates a divided clock-enable

---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_core.sv | 47 ++++
 rtl/clk_div_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock-divider controller:
// one-hot controller states and the smallest legal divide ratio.
package clk_div_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'b0001,
        RUN    = 4'b0010,
        SWITCH = 4'b0100,
        STOP   = 4'b1000
    } state_t;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_div_core.sv
// Phase counter and registered output of the divider. Produces the divided
// waveform and a registered wrap flag that is high on the last cycle of a period.
module clk_div_core #(
    parameter int DIV_W = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             run,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             clk_div_out,
    output logic             wrap
);

    logic [DIV_W-1:0] ph_q, ph_d;
    logic [DIV_W:0]   low;
    logic             out_q, out_d;
    logic             wrap_q, wrap_d;

    // ph_d is zero whenever div may change (restart or boundary), so comparing
    // against the current div keeps the output and wrap flops exact.
    always_comb begin
        low = ({1'b0, div} + {{DIV_W{1'b0}}, 1'b1}) >> 1;
        if (!run || restart || wrap_q)
            ph_d = '0;
        else
            ph_d = ph_q + DIV_W'(1);
        out_d  = run && ({1'b0, ph_d} >= low);
        wrap_d = run && (ph_d == div - DIV_W'(1));
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            ph_q   <= '0;
            out_q  <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign clk_div_out = out_q;
    assign wrap        = wrap_q;

endmodule

// File: rtl/clk_div_ctrl.sv
// Run-time programmable clock-divider controller with valid/ready ratio port.
// Define CLK_DIV_CTRL_PCNT_EN to add the 16-bit period_cnt output.
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W   = 4,
    parameter int DEF_DIV = 7
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_div_out,
    output logic             period_tick,
    output logic             busy,
    output logic [DIV_W-1:0] cur_div
`ifdef CLK_DIV_CTRL_PCNT_EN
    ,
    output logic [15:0]      period_cnt
`endif
);

    state_t           state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pend_q, pend_d;
    logic             err_q, err_d;
    logic             run_like, take, legal, load;
    logic             wrap;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        pend_d    = pend_q;
        load      = 1'b0;
        // STOP with en back high behaves exactly like RUN, including accepting requests.
        run_like  = (state_q == RUN) || ((state_q == STOP) && en);
        cfg_ready = (state_q == IDLE) || run_like;
        take      = cfg_valid && cfg_ready;
        legal     = cfg_div >= DIV_W'(MIN_DIV);
        err_d     = take && !legal;
        case (state_q)
            IDLE: begin
                if (take && legal) begin
                    div_d = cfg_div;
                    load  = 1'b1;
                end
                if (en)
                    state_d = RUN;
            end
            SWITCH: begin
                if (wrap) begin
                    div_d   = pend_q;
                    load    = 1'b1;
                    state_d = en ? RUN : IDLE;
                end
            end
            default: begin
                if (run_like) begin
                    if (take && legal) begin
                        pend_d  = cfg_div;
                        state_d = SWITCH;
                    end else begin
                        state_d = en ? RUN : STOP;
                    end
                end else if (wrap) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= IDLE;
            div_q   <= DIV_W'(DEF_DIV);
            pend_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
        end
    end

    clk_div_core #(.DIV_W(DIV_W)) u_core (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .run         (state_d != IDLE),
        .restart     (state_q == IDLE),
        .div         (div_q),
        .clk_div_out (clk_div_out),
        .wrap        (wrap)
    );

    assign period_tick = wrap;
    assign cfg_err     = err_q;
    assign busy        = (state_q != IDLE);
    assign cur_div     = div_q;

`ifdef CLK_DIV_CTRL_PCNT_EN
    logic [15:0] pcnt_q;

    // An applied ratio change restarts the count even if a tick lands on the same cycle.
    always_ff @(posedge sys_clk) begin
        if (sys_rst)
            pcnt_q <= '0;
        else if (load)
            pcnt_q <= '0;
        else if (wrap)
            pcnt_q <= pcnt_q + 16'd1;
    end

    assign period_cnt = pcnt_q;
`endif

endmodule
